// File: rtl/cam_soc_sysid_pkg.sv
// Shared definitions for the system-ID boot checker.
package cam_soc_sysid_pkg;

  localparam int unsigned SYSID_DATA_W = 32;

  // Word addresses inside the system-ID slave.
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // StRetry is the one-cycle gap with avm_read low between a timed-out read and the restart.
  typedef enum logic [2:0] {
    StIdle,
    StRdId,
    StRdTs,
    StRetry,
    StCompare,
    StPass,
    StFail
  } sysid_state_e;

  // True while a read strobe is on the bus.
  function automatic logic is_read_state(input sysid_state_e state);
    return (state == StRdId) || (state == StRdTs);
  endfunction

endpackage

// File: rtl/cam_soc_timeout_counter.sv
// Counts consecutive stalled read cycles; flags the cycle whose increment reaches Limit.
module cam_soc_timeout_counter #(
  parameter int unsigned Width = 8,
  parameter int unsigned Limit = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam logic [Width-1:0] LastCount = Width'(Limit - 1);

  logic [Width-1:0] count_q;

  // Stall counter; clear wins over increment.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Asserted on the stalled cycle that brings the count up to Limit.
  assign expired = inc && !clr && (count_q == LastCount);

endmodule

// File: rtl/cam_soc_sysid_checker.sv
// Boot-time check of the system-ID slave: reads ID and timestamp, compares them against
// build-time values and enables the encryption datapath only on a match.
module cam_soc_sysid_checker
  import cam_soc_sysid_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TS    = 32'h0000_0000,
  parameter bit                      CHECK_TS       = 1'b1,
  parameter int unsigned             TIMEOUT_CYCLES = 255,
  parameter int unsigned             MAX_RETRIES    = 3,
  parameter bit                      AUTO_START     = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    avm_address,
  output logic                    avm_read,
  input  logic                    avm_waitrequest,
  input  logic [SYSID_DATA_W-1:0] avm_readdata,
  output logic                    busy,
  output logic                    done,
  output logic                    id_ok,
  output logic                    id_fail,
  output logic                    timed_out,
  output logic [SYSID_DATA_W-1:0] sys_id,
  output logic [SYSID_DATA_W-1:0] sys_ts,
  output logic                    run_enable
);

  localparam int unsigned TmoW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RetryW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  sysid_state_e            state_q;
  logic                    read_q;
  logic                    addr_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    id_ok_q;
  logic                    id_fail_q;
  logic                    timed_out_q;
  logic [SYSID_DATA_W-1:0] sys_id_q;
  logic [SYSID_DATA_W-1:0] sys_ts_q;
  logic [RetryW-1:0]       retry_q;

  logic tmo_inc;
  logic tmo_clr;
  logic tmo_expired;
  logic compare_pass;
  logic retries_spent;

  // Only stalled cycles of an active read count towards the timeout.
  assign tmo_inc = is_read_state(state_q) && avm_waitrequest;
  assign tmo_clr = !tmo_inc;

  cam_soc_timeout_counter #(
    .Width (TmoW),
    .Limit (TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (tmo_inc),
    .clr     (tmo_clr),
    .expired (tmo_expired)
  );

  assign compare_pass  = (sys_id_q == EXPECTED_ID) && (!CHECK_TS || (sys_ts_q == EXPECTED_TS));
  assign retries_spent = (retry_q == RetryW'(MAX_RETRIES));

  // Check sequencer with registered bus strobes, capture registers and result flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      read_q      <= 1'b0;
      addr_q      <= SYSID_ADDR_ID;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      id_ok_q     <= 1'b0;
      id_fail_q   <= 1'b0;
      timed_out_q <= 1'b0;
      sys_id_q    <= '0;
      sys_ts_q    <= '0;
      retry_q     <= '0;
    end else if (tmo_expired) begin
      // Abandon the stalled read; the slave is stateless so dropping the strobe is harmless.
      read_q <= 1'b0;
      addr_q <= SYSID_ADDR_ID;
      if (retries_spent) begin
        busy_q      <= 1'b0;
        done_q      <= 1'b1;
        id_fail_q   <= 1'b1;
        timed_out_q <= 1'b1;
        state_q     <= StFail;
      end else begin
        retry_q <= retry_q + 1'b1;
        state_q <= StRetry;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (AUTO_START || start) begin
            read_q  <= 1'b1;
            addr_q  <= SYSID_ADDR_ID;
            busy_q  <= 1'b1;
            state_q <= StRdId;
          end
        end
        StRdId: begin
          if (!avm_waitrequest) begin
            sys_id_q <= avm_readdata;
            addr_q   <= SYSID_ADDR_TS;
            state_q  <= StRdTs;
          end
        end
        StRdTs: begin
          if (!avm_waitrequest) begin
            sys_ts_q <= avm_readdata;
            read_q   <= 1'b0;
            addr_q   <= SYSID_ADDR_ID;
            state_q  <= StCompare;
          end
        end
        StRetry: begin
          read_q  <= 1'b1;
          addr_q  <= SYSID_ADDR_ID;
          state_q <= StRdId;
        end
        StCompare: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (compare_pass) begin
            id_ok_q <= 1'b1;
            state_q <= StPass;
          end else begin
            id_fail_q <= 1'b1;
            state_q   <= StFail;
          end
        end
        StPass, StFail: begin
          // Re-check: results drop on the accepting edge, captured words linger until rewritten.
          if (start) begin
            done_q      <= 1'b0;
            id_ok_q     <= 1'b0;
            id_fail_q   <= 1'b0;
            timed_out_q <= 1'b0;
            retry_q     <= '0;
            read_q      <= 1'b1;
            addr_q      <= SYSID_ADDR_ID;
            busy_q      <= 1'b1;
            state_q     <= StRdId;
          end
        end
        default: begin
          read_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign id_fail     = id_fail_q;
  assign timed_out   = timed_out_q;
  assign sys_id      = sys_id_q;
  assign sys_ts      = sys_ts_q;
  assign run_enable  = id_ok_q;

endmodule

// File: tb/tb_cam_soc_sysid_checker.sv
// Scoreboard bench for the system-ID checker: a stall-programmable slave, a cycle-level
// outcome predictor and a monitor that compares every completed check.
module tb_cam_soc_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h5716_4EA2;
  localparam int TMO  = 4;
  localparam int MAXR = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        busy, done, id_ok, id_fail, timed_out, run_enable;
  logic [31:0] sys_id, sys_ts;

  cam_soc_sysid_checker #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .CHECK_TS       (1'b1),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRIES    (MAXR),
    .AUTO_START     (1'b1)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .id_fail         (id_fail),
    .timed_out       (timed_out),
    .sys_id          (sys_id),
    .sys_ts          (sys_ts),
    .run_enable      (run_enable)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          done_cyc;
    bit          ok;
    bit          fail;
    bit          to;
    logic [31:0] id;
    logic [31:0] ts;
  } exp_t;

  exp_t        exp_q[$];
  int          stall_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          last_done = 0;
  int          read_rises = 0;
  logic [31:0] m_sys_id = '0;
  logic [31:0] m_sys_ts = '0;
  logic [31:0] slave_id = '0;
  logic [31:0] slave_ts = '0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Outcome of one check from the slave's per-read stall list: a read stalled TMO cycles
  // is abandoned, costs one idle cycle and restarts from the ID word.
  function automatic void predict(input int s, input int st[$], input logic [31:0] id,
                                  input logic [31:0] ts);
    exp_t e;
    int   r = s;
    int   retries = 0;
    int   k = 0;
    bit   on_ts = 1'b0;
    int   stall;
    e.ok = 1'b0;
    e.fail = 1'b0;
    e.to = 1'b0;
    forever begin
      stall = (k < st.size()) ? st[k] : 0;
      k++;
      if (stall >= TMO) begin
        r += TMO;
        retries++;
        if (retries > MAXR) begin
          e.fail = 1'b1;
          e.to = 1'b1;
          break;
        end
        r += 1;
        on_ts = 1'b0;
      end else begin
        r += stall + 1;
        if (!on_ts) begin
          m_sys_id = id;
          on_ts = 1'b1;
        end else begin
          m_sys_ts = ts;
          r += 1;
          e.ok = (id == EXP_ID) && (ts == EXP_TS);
          e.fail = !e.ok;
          break;
        end
      end
    end
    e.done_cyc = r;
    e.id = m_sys_id;
    e.ts = m_sys_ts;
    last_done = r;
    exp_q.push_back(e);
  endfunction

  // Slave: each new read transaction takes its stall count from stall_q (0 when empty);
  // data is garbage while stalled.
  int   stall_left = 0;
  bit   in_txn = 1'b0;
  logic s_rd = 1'b0;
  logic s_wr = 1'b0;
  always @(negedge clock) begin
    if (s_rd && s_wr) stall_left--;
    else if (s_rd) in_txn = 1'b0;
    if (avm_read) begin
      if (!in_txn) begin
        in_txn = 1'b1;
        stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
      end
      avm_waitrequest = (stall_left > 0);
      if (avm_waitrequest) avm_readdata = $urandom;
      else avm_readdata = avm_address ? slave_ts : slave_id;
    end else begin
      in_txn = 1'b0;
      avm_waitrequest = 1'($urandom_range(0, 1));
      avm_readdata = $urandom;
    end
    s_rd = avm_read;
    s_wr = avm_waitrequest;
  end

  // Monitor: per-cycle invariants, and a scoreboard pop on every rising done.
  logic m_rd = 1'b0;
  logic m_wr = 1'b0;
  logic m_addr = 1'b0;
  logic m_done = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    #1;
    chk1("run_enable_eq_id_ok", run_enable, id_ok);
    chk1("run_enable_while_busy", run_enable && busy, 1'b0);
    if (m_rd && m_wr && avm_read) chk1("addr_stable_stalled", avm_address, m_addr);
    if (avm_read && !m_rd) read_rises++;
    if (done && !m_done) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: done rose at cycle %0d with no check pending", cyc);
      end else begin
        e = exp_q.pop_front();
        chk32("done_cycle", cyc, e.done_cyc);
        chk1("id_ok", id_ok, e.ok);
        chk1("id_fail", id_fail, e.fail);
        chk1("timed_out", timed_out, e.to);
        chk1("run_enable", run_enable, e.ok);
        chk1("busy_at_done", busy, 1'b0);
        chk32("sys_id", sys_id, e.id);
        chk32("sys_ts", sys_ts, e.ts);
      end
    end
    m_rd = avm_read;
    m_wr = avm_waitrequest;
    m_addr = avm_address;
    m_done = done;
  end

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_wait: %0d checks still pending after %0d cycles", exp_q.size(), n);
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  // mode 0: plain re-check; 1: extra start mid-run; 2: start coincident with the done edge.
  task automatic launch_and_check(input logic [31:0] id, input logic [31:0] ts,
                                  input int st[$], input int mode);
    logic [31:0] pid, pts;
    @(negedge clock);
    slave_id = id;
    slave_ts = ts;
    stall_q = st;
    pid = m_sys_id;
    pts = m_sys_ts;
    start = 1'b1;
    predict(cyc + 1, st, id, ts);
    @(negedge clock);
    start = 1'b0;
    chk1("restart_done_clr", done, 1'b0);
    chk1("restart_ok_clr", id_ok, 1'b0);
    chk1("restart_fail_clr", id_fail, 1'b0);
    chk1("restart_to_clr", timed_out, 1'b0);
    chk1("restart_run_en_clr", run_enable, 1'b0);
    chk1("restart_busy", busy, 1'b1);
    chk32("restart_sys_id_kept", sys_id, pid);
    chk32("restart_sys_ts_kept", sys_ts, pts);
    if (mode == 1) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end else if (mode == 2) begin
      while (cyc < last_done - 1) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      chk1("coincident_start_busy", busy, 1'b0);
      chk1("coincident_start_done", done, 1'b1);
    end
    wait_done();
    stall_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st[$];
    logic [31:0] rid, rts;
    int          pick;

    reset_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clock);
    chk1("rst_read", avm_read, 1'b0);
    chk1("rst_addr", avm_address, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_id_ok", id_ok, 1'b0);
    chk1("rst_id_fail", id_fail, 1'b0);
    chk1("rst_timed_out", timed_out, 1'b0);
    chk1("rst_run_enable", run_enable, 1'b0);
    chk32("rst_sys_id", sys_id, 32'h0);
    chk32("rst_sys_ts", sys_ts, 32'h0);

    // Auto-start, zero-wait slave, matching words.
    slave_id = EXP_ID;
    slave_ts = EXP_TS;
    st = {0, 0};
    stall_q = st;
    reset_n = 1'b1;
    predict(cyc + 1, st, EXP_ID, EXP_TS);
    @(negedge clock);
    chk1("e1_read", avm_read, 1'b1);
    chk1("e1_addr", avm_address, 1'b0);
    chk1("e1_busy", busy, 1'b1);
    @(negedge clock);
    chk1("e2_read", avm_read, 1'b1);
    chk1("e2_addr", avm_address, 1'b1);
    chk32("e2_sys_id", sys_id, EXP_ID);
    @(negedge clock);
    chk1("e3_read", avm_read, 1'b0);
    chk32("e3_sys_ts", sys_ts, EXP_TS);
    wait_done();

    // Wrong ID, then corrected slave with a stray start mid-run, then stalls of 3.
    st = {0, 0};
    launch_and_check(32'h0000_0001, EXP_TS, st, 0);
    st = {0, 0};
    launch_and_check(EXP_ID, EXP_TS, st, 1);
    st = {3, 3};
    launch_and_check(EXP_ID, EXP_TS, st, 1);

    // Waitrequest stuck: MAXR restarts, then timeout failure.
    st = {100, 100, 100};
    read_rises = 0;
    launch_and_check(EXP_ID, EXP_TS, st, 0);
    chk32("timeout_read_attempts", read_rises, MAXR + 1);

    // Start landing on the edge that finishes the check.
    st = {1, 0};
    launch_and_check(EXP_ID, EXP_TS, st, 2);

    for (int i = 0; i < 16; i++) begin
      pick = $urandom_range(0, 3);
      rid = (pick == 1) ? 32'h1 : (pick == 2) ? 32'($urandom) : EXP_ID;
      rts = ($urandom_range(0, 2) != 0) ? EXP_TS : 32'($urandom);
      st = {};
      for (int k = 0; k < 6; k++) begin
        st.push_back(($urandom_range(0, 7) < 6) ? $urandom_range(0, 3) : $urandom_range(4, 6));
      end
      launch_and_check(rid, rts, st, $urandom_range(0, 2));
    end

    // Reset during the timestamp read, then auto-start after release.
    @(negedge clock);
    slave_id = 32'hDEAD_BEEF;
    slave_ts = 32'h1234_5678;
    st = {0, 3};
    stall_q = st;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk1("mid_rd_ts_addr", avm_address, 1'b1);
    chk1("mid_rd_ts_read", avm_read, 1'b1);
    reset_n = 1'b0;
    @(negedge clock);
    chk1("midrst_read", avm_read, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk1("midrst_run_enable", run_enable, 1'b0);
    chk32("midrst_sys_id", sys_id, 32'h0);
    chk32("midrst_sys_ts", sys_ts, 32'h0);
    m_sys_id = '0;
    m_sys_ts = '0;
    stall_q.delete();
    @(negedge clock);
    slave_id = EXP_ID;
    slave_ts = EXP_TS;
    st = {2, 1};
    stall_q = st;
    reset_n = 1'b1;
    predict(cyc + 1, st, EXP_ID, EXP_TS);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
